// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        HALT,
        ERROR
    } fetch_state_t;

    localparam logic [31:0] NOP                 = 32'h0000_0000;
    localparam logic [31:0] HALT_OPCODE_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts FETCH cycles without a memory ack; expired flags the last allowed cycle.
module fetch_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic resetL,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetL || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    // High during the TIMEOUT-th waiting cycle, so the FSM leaves on that edge.
    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch/execute sequencer: fetches one word per instruction at pc, stalls the core until
// cpu_done, counts retirements and stops on halt opcode, instruction limit or fetch timeout.
module instr_fetch_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int                 ADDR_W      = 32,
    parameter int                 DATA_W      = 32,
    parameter logic [DATA_W-1:0]  HALT_OPCODE = DATA_W'(HALT_OPCODE_DEFAULT),
    parameter int                 MAX_INSTR   = 1024,
    parameter int                 TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              resetL,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] inst,
    output logic              cpu_stall,
    input  logic              cpu_done,
    output logic [15:0]       instr_cnt,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    fetch_state_t state;
    logic         wdExpired;
    logic [15:0]  nextCnt;

    assign nextCnt = instr_cnt + 16'd1;

    // Held cleared outside FETCH, so every entry into FETCH starts a fresh window.
    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) uWatchdog (
        .clk     (clk),
        .resetL  (resetL),
        .clear   (state != FETCH),
        .enable  ((state == FETCH) && !mem_ack),
        .expired (wdExpired)
    );

    always_ff @(posedge clk) begin
        if (!resetL) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            inst      <= DATA_W'(NOP);
            cpu_stall <= 1'b1;
            instr_cnt <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state     <= FETCH;
                        mem_addr  <= pc;
                        instr_cnt <= '0;
                        mem_req   <= 1'b1;
                        cpu_stall <= 1'b1;
                        busy      <= 1'b1;
                        halted    <= 1'b0;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (mem_rdata == HALT_OPCODE) begin
                            state     <= HALT;
                            inst      <= DATA_W'(NOP);
                            cpu_stall <= 1'b1;
                            busy      <= 1'b0;
                            halted    <= 1'b1;
                        end else begin
                            state     <= EXEC;
                            inst      <= mem_rdata;
                            cpu_stall <= 1'b0;
                        end
                    end else if (wdExpired) begin
                        state     <= ERROR;
                        mem_req   <= 1'b0;
                        cpu_stall <= 1'b1;
                        busy      <= 1'b0;
                        err       <= 1'b1;
                    end
                end
                EXEC: begin
                    if (cpu_done) begin
                        instr_cnt <= nextCnt;
                        cpu_stall <= 1'b1;
                        if (nextCnt == 16'(MAX_INSTR)) begin
                            state  <= HALT;
                            inst   <= DATA_W'(NOP);
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            mem_addr <= pc;
                            mem_req  <= 1'b1;
                        end
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed scoreboard bench for instr_fetch_ctrl (MAX_INSTR = 4, TIMEOUT = 16).
module tb_instr_fetch_ctrl;

    // Status word packing: {mem_req, cpu_stall, busy, halted, err}
    localparam logic [4:0] S_IDLE  = 5'b01000;
    localparam logic [4:0] S_FETCH = 5'b11100;
    localparam logic [4:0] S_EXEC  = 5'b00100;
    localparam logic [4:0] S_HALT  = 5'b01010;
    localparam logic [4:0] S_ERROR = 5'b01001;

    logic        clk = 1'b0;
    logic        resetL = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] inst;
    logic        cpu_stall;
    logic        cpu_done = 1'b0;
    logic [15:0] instr_cnt;
    logic        busy;
    logic        halted;
    logic        err;

    int          nCmp = 0;
    int          nErr = 0;
    string       tagQ[$];
    logic [31:0] valQ[$];

    instr_fetch_ctrl #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .HALT_OPCODE (32'hFFFF_FFFF),
        .MAX_INSTR   (4),
        .TIMEOUT     (16)
    ) dut (
        .clk       (clk),
        .resetL    (resetL),
        .start     (start),
        .pc        (pc),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .inst      (inst),
        .cpu_stall (cpu_stall),
        .cpu_done  (cpu_done),
        .instr_cnt (instr_cnt),
        .busy      (busy),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushE(input string tag, input logic [31:0] v);
        tagQ.push_back(tag);
        valQ.push_back(v);
    endtask

    task automatic popC(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        nCmp++;
        if (valQ.size() == 0) begin
            nErr++;
            $error("FAIL scoreboard_empty: observed %h required nothing queued", obs);
        end else begin
            t = tagQ.pop_front();
            e = valQ.pop_front();
            assert (obs === e) else begin
                nErr++;
                $error("FAIL %s: observed %h required %h", t, obs, e);
            end
        end
    endtask

    function automatic logic [31:0] stat();
        return {27'd0, mem_req, cpu_stall, busy, halted, err};
    endfunction

    // One instruction: ack with word, check EXEC, then cpu_done with nextPc on pc.
    task automatic runInstr(input logic [31:0] word, input logic [31:0] nextPc,
                            input logic [15:0] expCnt, input logic [4:0] expStat);
        mem_ack = 1'b1;
        mem_rdata = word;
        pushE("exec_inst", word);
        pushE("exec_status", {27'd0, S_EXEC});
        tick();
        mem_ack = 1'b0;
        popC(inst);
        popC(stat());
        pc = nextPc;
        cpu_done = 1'b1;
        pushE("done_cnt", {16'd0, expCnt});
        pushE("done_status", {27'd0, expStat});
        tick();
        cpu_done = 1'b0;
        popC({16'd0, instr_cnt});
        popC(stat());
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        pushE("rst_status", {27'd0, S_IDLE});
        pushE("rst_inst", 32'h0);
        pushE("rst_addr", 32'h0);
        pushE("rst_cnt", 32'h0);
        popC(stat());
        popC(inst);
        popC(mem_addr);
        popC({16'd0, instr_cnt});
        resetL = 1'b1;

        // Basic fetch/exec at pc 0x40
        pc = 32'h40;
        start = 1'b1;
        pushE("t1_status", {27'd0, S_FETCH});
        pushE("t1_addr", 32'h40);
        tick();
        start = 1'b0;
        popC(stat());
        popC(mem_addr);
        mem_ack = 1'b1;
        mem_rdata = 32'h0000_1234;
        pushE("t1_inst", 32'h0000_1234);
        pushE("t1_exec", {27'd0, S_EXEC});
        tick();
        mem_ack = 1'b0;
        popC(inst);
        popC(stat());
        pc = 32'h44;
        cpu_done = 1'b1;
        pushE("t1_cnt", 32'd1);
        pushE("t1_refetch", {27'd0, S_FETCH});
        pushE("t1_addr2", 32'h44);
        tick();
        cpu_done = 1'b0;
        popC({16'd0, instr_cnt});
        popC(stat());
        popC(mem_addr);

        // Two more instructions, then the halt opcode
        runInstr(32'h2222, 32'h48, 16'd2, S_FETCH);
        runInstr(32'h3333, 32'h4C, 16'd3, S_FETCH);
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        pushE("halt_status", {27'd0, S_HALT});
        pushE("halt_cnt", 32'd3);
        pushE("halt_inst", 32'h0);
        tick();
        mem_ack = 1'b0;
        popC(stat());
        popC({16'd0, instr_cnt});
        popC(inst);

        // Restart from HALT, then spurious cpu_done / mem_ack / start
        pc = 32'h100;
        start = 1'b1;
        pushE("rs_status", {27'd0, S_FETCH});
        pushE("rs_cnt", 32'd0);
        pushE("rs_addr", 32'h100);
        tick();
        start = 1'b0;
        popC(stat());
        popC({16'd0, instr_cnt});
        popC(mem_addr);
        cpu_done = 1'b1;
        pushE("sp_done_status", {27'd0, S_FETCH});
        pushE("sp_done_cnt", 32'd0);
        tick();
        cpu_done = 1'b0;
        popC(stat());
        popC({16'd0, instr_cnt});
        mem_ack = 1'b1;
        mem_rdata = 32'h5;
        pushE("sp_exec", {27'd0, S_EXEC});
        pushE("sp_inst", 32'h5);
        tick();
        popC(stat());
        popC(inst);
        mem_rdata = 32'hAAAA;
        pushE("sp_ack_status", {27'd0, S_EXEC});
        pushE("sp_ack_inst", 32'h5);
        tick();
        mem_ack = 1'b0;
        popC(stat());
        popC(inst);
        start = 1'b1;
        pushE("sp_start_status", {27'd0, S_EXEC});
        pushE("sp_start_cnt", 32'd0);
        tick();
        start = 1'b0;
        popC(stat());
        popC({16'd0, instr_cnt});
        pc = 32'h104;
        cpu_done = 1'b1;
        pushE("sp_cnt1", 32'd1);
        pushE("sp_fetch", {27'd0, S_FETCH});
        tick();
        cpu_done = 1'b0;
        popC({16'd0, instr_cnt});
        popC(stat());

        // Instruction limit: 4th cpu_done enters HALT
        runInstr(32'h6, 32'h108, 16'd2, S_FETCH);
        runInstr(32'h7, 32'h10C, 16'd3, S_FETCH);
        runInstr(32'h8, 32'h110, 16'd4, S_HALT);
        pushE("max_inst", 32'h0);
        popC(inst);
        mem_ack = 1'b1;
        mem_rdata = 32'h9;
        for (int i = 0; i < 3; i++) begin
            pushE("max_no_req", {27'd0, S_HALT});
            tick();
            popC(stat());
        end
        mem_ack = 1'b0;

        // Reset mid-EXEC wins over start/cpu_done/mem_ack
        pc = 32'h300;
        start = 1'b1;
        pushE("mr_fetch", {27'd0, S_FETCH});
        tick();
        start = 1'b0;
        popC(stat());
        mem_ack = 1'b1;
        mem_rdata = 32'h77;
        pushE("mr_exec", {27'd0, S_EXEC});
        tick();
        mem_ack = 1'b0;
        popC(stat());
        resetL = 1'b0;
        start = 1'b1;
        cpu_done = 1'b1;
        mem_ack = 1'b1;
        pushE("mr_status", {27'd0, S_IDLE});
        pushE("mr_inst", 32'h0);
        pushE("mr_addr", 32'h0);
        pushE("mr_cnt", 32'h0);
        tick();
        popC(stat());
        popC(inst);
        popC(mem_addr);
        popC({16'd0, instr_cnt});
        resetL = 1'b1;
        start = 1'b0;
        cpu_done = 1'b0;
        mem_ack = 1'b0;
        pc = 32'h310;
        start = 1'b1;
        pushE("mr_restart", {27'd0, S_FETCH});
        pushE("mr_restart_cnt", 32'd0);
        pushE("mr_restart_addr", 32'h310);
        tick();
        start = 1'b0;
        popC(stat());
        popC({16'd0, instr_cnt});
        popC(mem_addr);
        runInstr(32'h99, 32'h314, 16'd1, S_FETCH);

        // Watchdog: slow ack first, then a clean 16-cycle timeout after re-entry
        resetL = 1'b0;
        tick();
        resetL = 1'b1;
        pc = 32'h400;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        runInstr(32'hA, 32'h404, 16'd1, S_FETCH);
        for (int i = 0; i < 15; i++) tick();
        pushE("wd_15", {27'd0, S_FETCH});
        popC(stat());
        pushE("wd_16", {27'd0, S_ERROR});
        tick();
        popC(stat());
        start = 1'b1;
        pushE("wd_start_ignored", {27'd0, S_ERROR});
        tick();
        start = 1'b0;
        popC(stat());
        resetL = 1'b0;
        pushE("wd_reset", {27'd0, S_IDLE});
        tick();
        resetL = 1'b1;
        popC(stat());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
